// File: rtl/priority_encoder_4to2.sv
// 4-to-2 priority encoder: Y is the index of the highest set bit of D, V = |D.
// Optional registered output stage with asynchronous active-high reset.
module priority_encoder_4to2 #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D,
  output logic [1:0] Y,
  output logic       V
);

  logic [1:0] y_next;
  logic       v_next;

  // Ascending scan so the highest asserted bit wins the final assignment.
  always_comb begin
    y_next = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (D[i]) begin
        y_next = 2'(i);
      end
    end
    v_next = |D;
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [1:0] y_reg;
      logic       v_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          y_reg <= 2'b00;
          v_reg <= 1'b0;
        end else begin
          y_reg <= y_next;
          v_reg <= v_next;
        end
      end

      assign Y = y_reg;
      assign V = v_reg;
    end else begin : g_comb
      // clk/rst are intentionally ignored in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      assign Y = y_next;
      assign V = v_next;
    end
  endgenerate

endmodule

// File: tb/tb_priority_encoder_4to2.sv
// Self-checking bench: registered and combinational builds of priority_encoder_4to2
// checked against a log2-style reference model with directed and random stimulus.
module tb_priority_encoder_4to2;

  logic       clk;
  logic       rst;
  logic [3:0] d;
  logic [1:0] y_r;
  logic       v_r;
  logic [1:0] y_c;
  logic       v_c;

  int checks = 0;
  int errors = 0;

  priority_encoder_4to2 #(.REG_OUT(1'b1)) dut_reg (
    .clk (clk),
    .rst (rst),
    .D   (d),
    .Y   (y_r),
    .V   (v_r)
  );

  priority_encoder_4to2 #(.REG_OUT(1'b0)) dut_comb (
    .clk (clk),
    .rst (rst),
    .D   (d),
    .Y   (y_c),
    .V   (v_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: floor(log2(d)) by repeated halving; 0 when nothing is asserted.
  function automatic logic [1:0] model_y(input logic [3:0] val);
    int n;
    int idx;
    n = int'(val);
    idx = 0;
    while (n > 1) begin
      n = n / 2;
      idx++;
    end
    return 2'(idx);
  endfunction

  function automatic logic model_v(input logic [3:0] val);
    return val != 4'd0;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive d between edges, check the combinational build, then the registered one after the edge.
  task automatic apply(input string tag, input logic [3:0] val);
    @(negedge clk);
    d = val;
    #1;
    check({tag, "_comb_y"}, {2'b00, y_c}, {2'b00, model_y(val)});
    check({tag, "_comb_v"}, {3'b000, v_c}, {3'b000, model_v(val)});
    @(posedge clk);
    #1;
    check({tag, "_reg_y"}, {2'b00, y_r}, {2'b00, model_y(val)});
    check({tag, "_reg_v"}, {3'b000, v_r}, {3'b000, model_v(val)});
    $display("txn %-10s d=%b y=%b v=%b", tag, val, y_r, v_r);
  endtask

  logic [3:0] rnd;

  initial begin
    rst = 1'b0;
    d   = 4'b1000;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_async_y", {2'b00, y_r}, 4'd0);
    check("rst_async_v", {3'b000, v_r}, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_y", {2'b00, y_r}, 4'd0);
    check("rst_hold_v", {3'b000, v_r}, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rel_y", {2'b00, y_r}, 4'b0011);
    check("rst_rel_v", {3'b000, v_r}, 4'd1);

    // One-hot sweep, none asserted, all asserted, priority masking.
    apply("onehot0", 4'b0001);
    apply("onehot1", 4'b0010);
    apply("onehot2", 4'b0100);
    apply("onehot3", 4'b1000);
    apply("none", 4'b0000);
    apply("all", 4'b1111);
    apply("mask0011", 4'b0011);
    apply("mask0110", 4'b0110);
    apply("mask1010", 4'b1010);

    // Latency: output holds its previous value until the next edge.
    apply("lat_pre", 4'b0001);
    @(negedge clk);
    d = 4'b1000;
    #1;
    check("lat_hold_y", {2'b00, y_r}, 4'd0);
    check("lat_hold_v", {3'b000, v_r}, 4'd1);
    @(posedge clk);
    #1;
    check("lat_upd_y", {2'b00, y_r}, 4'b0011);
    check("lat_upd_v", {3'b000, v_r}, 4'd1);

    // Mid-stream reset pulse discards the pending result.
    @(negedge clk);
    d = 4'b0100;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_y", {2'b00, y_r}, 4'd0);
    check("mid_rst_v", {3'b000, v_r}, 4'd0);
    @(posedge clk);
    #1;
    check("mid_edge_y", {2'b00, y_r}, 4'd0);
    check("mid_edge_v", {3'b000, v_r}, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rel_y", {2'b00, y_r}, 4'd0);
    check("mid_rel_v", {3'b000, v_r}, 4'd0);
    @(posedge clk);
    #1;
    check("mid_cap_y", {2'b00, y_r}, 4'b0010);
    check("mid_cap_v", {3'b000, v_r}, 4'd1);

    // Random stimulus.
    for (int i = 0; i < 24; i++) begin
      rnd = 4'($urandom_range(0, 15));
      apply("rand", rnd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
